pipeline_hazard_ctrl: RTL and testbench

Central stall/bubble generator for the five-stage MIPS pipeline. Each pipeline register block has `*_stall` (hold) and `*_bubble` (load the bubble value) controls, and this block drives all of them. It detects load-use hazards between the D and E stages, freezes the pipeline while a data-memory access in M is not ready, and watches memory waits against a timeout. Optional performance counters record stall activity.

---
 rtl/pipeline_hazard_ctrl.sv | 178 +++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central stall/bubble generator for the five-stage MIPS pipeline.
//  - Detects load-use hazards between D and E and inserts one E bubble while
//    holding F and D.
//  - Freezes F/D/E/M and bubbles W while an M-stage data-memory access is not
//    ready (memory wait has priority over load-use).
//  - Tracks consecutive memory-wait cycles and raises a sticky mem_timeout
//    once WAIT_LIMIT consecutive wait cycles have elapsed.
//  - Optional stall/load-use performance counters, built only when the macro
//    PIPE_HAZARD_PERF_EN is defined.
//
// Parameters:
//   WAIT_LIMIT         consecutive wait cycles that raise mem_timeout (1..65535)
//
// Ports:
//   clk                clock, rising edge
//   resetn             asynchronous reset, active low
//   d_rs, d_rt         [4:0] source registers of the D instruction
//   d_use_rs, d_use_rt D instruction reads rs / rt
//   e_rn               [4:0] destination register of the E instruction
//   e_wreg, e_m2reg    E instruction writes a register / is a load
//   m_mem_req          M stage performs a data-memory access
//   mem_ready          data memory completes the access this cycle
//   f/d/e/m_stall      hold the F/D/E/M pipeline registers
//   d/e/m/w_bubble     load the bubble value into D/E/M/W pipeline registers
//   mem_timeout        sticky: a memory wait reached WAIT_LIMIT cycles
//   perf_stall_cycles  [31:0] cycles with f_stall high   (PIPE_HAZARD_PERF_EN)
//   perf_loaduse       [31:0] load-use bubbles inserted  (PIPE_HAZARD_PERF_EN)
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic        d_use_rs,
  input  logic        d_use_rt,
  input  logic [4:0]  e_rn,
  input  logic        e_wreg,
  input  logic        e_m2reg,
  input  logic        m_mem_req,
  input  logic        mem_ready,
  output logic        f_stall,
  output logic        d_stall,
  output logic        e_stall,
  output logic        m_stall,
  output logic        d_bubble,
  output logic        e_bubble,
  output logic        m_bubble,
  output logic        w_bubble,
`ifdef PIPE_HAZARD_PERF_EN
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_loaduse,
`endif
  output logic        mem_timeout
);

  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(WAIT_LIMIT);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  logic lu_hazard;
  logic mem_wait;

  state_t           state_reg,   state_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic             timeout_reg, timeout_next;

  // Register 0 is hard-wired, so a load targeting it never creates a hazard.
  assign lu_hazard = e_wreg & e_m2reg & (e_rn != 5'd0) &
                     ((d_use_rs & (e_rn == d_rs)) | (d_use_rt & (e_rn == d_rt)));
  assign mem_wait  = m_mem_req & ~mem_ready;

  // Reserved for the exception/branch-flush extension.
  assign d_bubble = 1'b0;
  assign m_bubble = 1'b0;

  // Pure function of the inputs: memory wait dominates; a load-use hazard
  // seen during a wait is simply re-evaluated after release since D/E hold.
  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    e_stall  = 1'b0;
    m_stall  = 1'b0;
    e_bubble = 1'b0;
    w_bubble = 1'b0;
    if (mem_wait) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_stall  = 1'b1;
      m_stall  = 1'b1;
      w_bubble = 1'b1;
    end else if (lu_hazard) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_bubble = 1'b1;
    end
  end

  // Wait-tracking FSM next state.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    timeout_next  = timeout_reg;
    case (state_reg)
      ST_RUN: begin
        if (mem_wait) begin
          state_next    = ST_WAIT;
          wait_cnt_next = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (mem_wait) begin
          if (wait_cnt_reg != LIMIT_C) begin
            wait_cnt_next = wait_cnt_reg + CNT_W'(1);
          end
        end else begin
          state_next    = ST_RUN;
          wait_cnt_next = '0;
        end
      end
      default: begin
        state_next    = ST_RUN;
        wait_cnt_next = '0;
      end
    endcase
    // Set on the edge where the count reaches the limit (covers WAIT_LIMIT=1,
    // where the very first wait cycle already hits it).
    if (mem_wait && (wait_cnt_next == LIMIT_C)) begin
      timeout_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg    <= ST_RUN;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      timeout_reg  <= timeout_next;
    end
  end

  assign mem_timeout = timeout_reg;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] loaduse_cnt_reg;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_reg   <= '0;
      loaduse_cnt_reg <= '0;
    end else begin
      if (f_stall && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (e_bubble && (loaduse_cnt_reg != 32'hFFFF_FFFF)) begin
        loaduse_cnt_reg <= loaduse_cnt_reg + 32'd1;
      end
    end
  end

  assign perf_stall_cycles = stall_cnt_reg;
  assign perf_loaduse      = loaduse_cnt_reg;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Self-checking bench for pipeline_hazard_ctrl (WAIT_LIMIT = 4). A behavioural
// reference model (run-length of consecutive waits, sticky timeout, plain
// integer counters) is compared against the DUT on every falling edge; a
// directed prologue pins the model with literal expectations, followed by
// randomized stimulus with occasional asynchronous reset pulses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam int L = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic [4:0] d_rs, d_rt, e_rn;
  logic       d_use_rs, d_use_rt, e_wreg, e_m2reg, m_mem_req, mem_ready;
  logic       f_stall, d_stall, e_stall, m_stall;
  logic       d_bubble, e_bubble, m_bubble, w_bubble, mem_timeout;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_loaduse;
`endif

  int total = 0;
  int bad   = 0;

  pipeline_hazard_ctrl #(.WAIT_LIMIT(L)) dut (
    .clk(clk), .resetn(resetn),
    .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
    .e_rn(e_rn), .e_wreg(e_wreg), .e_m2reg(e_m2reg),
    .m_mem_req(m_mem_req), .mem_ready(mem_ready),
    .f_stall(f_stall), .d_stall(d_stall), .e_stall(e_stall), .m_stall(m_stall),
    .d_bubble(d_bubble), .e_bubble(e_bubble), .m_bubble(m_bubble),
    .w_bubble(w_bubble),
`ifdef PIPE_HAZARD_PERF_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_loaduse(perf_loaduse),
`endif
    .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int  m_consec;      // consecutive wait cycles seen so far
  bit  m_timeout;
  longint m_stalls, m_lus;

  function automatic bit model_lu();
    bit rs_dep = d_use_rs && (d_rs == e_rn);
    bit rt_dep = d_use_rt && (d_rt == e_rn);
    return e_wreg && e_m2reg && (e_rn != 0) && (rs_dep || rt_dep);
  endfunction

  function automatic bit model_wait();
    return m_mem_req && !mem_ready;
  endfunction

  // {f,d,e,m stall, d,e,m,w bubble}
  function automatic logic [7:0] model_ctrl();
    if (model_wait()) return 8'b1111_0001;
    if (model_lu())   return 8'b1100_0100;
    return 8'b0000_0000;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_consec  = 0;
      m_timeout = 0;
      m_stalls  = 0;
      m_lus     = 0;
    end else begin
      if (model_ctrl() != 8'd0 && model_ctrl() != 8'b1111_0001) m_lus++;
      if (model_ctrl() != 8'd0) m_stalls++;
      m_consec = model_wait() ? m_consec + 1 : 0;
      if (m_consec >= L) m_timeout = 1;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("ctrl", {f_stall, d_stall, e_stall, m_stall, d_bubble, e_bubble, m_bubble, w_bubble},
          model_ctrl());
    check("timeout", mem_timeout, m_timeout);
`ifdef PIPE_HAZARD_PERF_EN
    check("perf_stall", perf_stall_cycles, m_stalls);
    check("perf_loaduse", perf_loaduse, m_lus);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    d_rs = 0; d_rt = 0; e_rn = 0; d_use_rs = 0; d_use_rt = 0;
    e_wreg = 0; e_m2reg = 0; m_mem_req = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    resetn = 0; next_cycle(); resetn = 1;
  endtask

  task automatic set_load(input logic [4:0] rn);
    e_rn = rn; e_wreg = 1; e_m2reg = 1;
  endtask

  initial begin
    idle_inputs();
    resetn = 0;
    #2;
    check("rst_timeout", mem_timeout, 0);
    check("rst_fstall", f_stall, 0);
    next_cycle(); resetn = 1;

    // Load-use on rs: exactly one bubble cycle.
    set_load(5); d_rs = 5; d_use_rs = 1;
    @(negedge clk);
    check("lu_fstall", f_stall, 1);
    check("lu_ebubble", e_bubble, 1);
    check("lu_estall", e_stall, 0);
    next_cycle(); idle_inputs();   // load moved to M
    @(negedge clk);
    check("lu_gone", e_bubble, 0);
`ifdef PIPE_HAZARD_PERF_EN
    check("lu_perf", perf_loaduse, 1);
`endif

    // Register zero and unused operand.
    next_cycle(); set_load(0); d_rs = 0; d_use_rs = 1;
    @(negedge clk); check("r0_nostall", f_stall, 0);
    next_cycle(); idle_inputs(); set_load(7); d_rt = 7; d_use_rt = 0;
    @(negedge clk); check("unused_rt", f_stall, 0);

    // Memory wait for 3 cycles, release in cycle 4.
    next_cycle(); idle_inputs(); do_reset();
    m_mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mw_mstall", m_stall, 1);
      check("mw_wbubble", w_bubble, 1);
      next_cycle();
    end
    mem_ready = 1;
    @(negedge clk);
    check("mw_release", f_stall, 0);
    check("mw_no_timeout", mem_timeout, 0);
`ifdef PIPE_HAZARD_PERF_EN
    check("mw_perf", perf_stall_cycles, 3);
`endif

    // Load-use during 2-cycle wait: freeze first, then one bubble.
    next_cycle(); set_load(9); d_rt = 9; d_use_rt = 1; mem_ready = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("sim_ebubble", e_bubble, 0);
      check("sim_estall", e_stall, 1);
      next_cycle();
    end
    mem_ready = 1;
    @(negedge clk); check("sim_lu_after", e_bubble, 1);

    // Timeout: 6 wait cycles, flag visible from cycle 5.
    next_cycle(); idle_inputs(); do_reset();
    m_mem_req = 1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("to_flag", mem_timeout, (k >= 5) ? 1 : 0);
      check("to_fstall", f_stall, 1);
      next_cycle();
    end
    mem_ready = 1;
    @(negedge clk); check("to_sticky", mem_timeout, 1);

    // Reset mid-wait (cycle 2), then a fresh 4-cycle wait is needed.
    next_cycle(); mem_ready = 0;
    @(negedge clk); next_cycle();
    @(negedge clk); #2 resetn = 0; #1;
    check("rstmid_timeout", mem_timeout, 0);
    next_cycle(); resetn = 1; mem_ready = 1;
    next_cycle(); mem_ready = 0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check("rstmid_flag", mem_timeout, (k >= 5) ? 1 : 0);
      next_cycle();
    end
    idle_inputs(); do_reset();

    // Randomized stimulus with small register ranges to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      d_rs      = 5'($urandom_range(0, 3));
      d_rt      = 5'($urandom_range(0, 3));
      e_rn      = 5'($urandom_range(0, 3));
      d_use_rs  = 1'($urandom_range(0, 1));
      d_use_rt  = 1'($urandom_range(0, 1));
      e_wreg    = ($urandom_range(0, 3) != 0);
      e_m2reg   = ($urandom_range(0, 1) != 0);
      m_mem_req = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      resetn    = ($urandom_range(0, 63) != 0);
      next_cycle();
    end
    resetn = 1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
